// File: rtl/count_event_monitor.sv
// Observer for the 8-bit load/increment counter: compare-match and wrap detection,
// saturating wrap count, level interrupt with ack. Optional macro WRAP_IRQ_EN lets wraps raise irq.
module count_event_monitor #(
  parameter int WRAP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        q_in,
  input  logic              ld_in,
  input  logic              inc_in,
  input  logic [7:0]        cmp_val,
  input  logic              cmp_en,
  input  logic              irq_ack,
  output logic              irq,
  output logic              sts_match,
  output logic              sts_wrap,
  output logic [WRAP_W-1:0] wrap_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    FIRED
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        prevCount_q;
  logic              ldDly_q;
  logic              incDly_q;
  logic [WRAP_W-1:0] wrapCnt_q, wrapCnt_d;
  logic              stsMatch_q, stsMatch_d;
  logic              stsWrap_q, stsWrap_d;
  logic              irq_q, irq_d;
  logic              wrapEvt;
  logic              matchEvt;

  // A load always wins over increment, so FF->00 only counts as a wrap when it was an increment.
  assign wrapEvt  = incDly_q & ~ldDly_q & (prevCount_q == 8'hFF) & (q_in == 8'h00);
  assign matchEvt = (q_in == cmp_val) & ((q_in != prevCount_q) | ldDly_q);

  always_comb begin
    state_d    = state_q;
    stsMatch_d = stsMatch_q;
    wrapCnt_d  = wrapCnt_q;
    stsWrap_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmp_en) state_d = ARMED;
      end
      ARMED: begin
        if (matchEvt) begin
          state_d    = FIRED;
          stsMatch_d = 1'b1;
        end else if (!cmp_en) begin
          state_d = IDLE;
        end
      end
      FIRED: begin
        // Matches while fired are absorbed; only the ack moves us on.
        if (irq_ack) begin
          stsMatch_d = 1'b0;
          state_d    = cmp_en ? ARMED : IDLE;
        end
      end
      default: begin
        state_d    = IDLE;
        stsMatch_d = 1'b0;
      end
    endcase

    if (wrapEvt && (wrapCnt_q != {WRAP_W{1'b1}})) begin
      wrapCnt_d = wrapCnt_q + {{(WRAP_W-1){1'b0}}, 1'b1};
    end

`ifdef WRAP_IRQ_EN
    if (wrapEvt) begin
      stsWrap_d = 1'b1;
    end else if (irq_ack) begin
      stsWrap_d = 1'b0;
    end else begin
      stsWrap_d = stsWrap_q;
    end
`else
    stsWrap_d = 1'b0;
`endif

    irq_d = stsMatch_d | stsWrap_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prevCount_q <= 8'h00;
      ldDly_q     <= 1'b0;
      incDly_q    <= 1'b0;
      wrapCnt_q   <= '0;
      stsMatch_q  <= 1'b0;
      stsWrap_q   <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      prevCount_q <= q_in;
      ldDly_q     <= ld_in;
      incDly_q    <= inc_in;
      wrapCnt_q   <= wrapCnt_d;
      stsMatch_q  <= stsMatch_d;
      stsWrap_q   <= stsWrap_d;
      irq_q       <= irq_d;
    end
  end

  assign irq       = irq_q;
  assign sts_match = stsMatch_q;
  assign sts_wrap  = stsWrap_q;
  assign wrap_cnt  = wrapCnt_q;

endmodule
